// File: rtl/mod_cfg_sequencer_pkg.sv
// Shared definitions for the modulator configuration sequencer: register map,
// control-word bit positions, FSM state encoding and the dwell helper.
package mod_cfg_pkg;

    // Shadow register addresses
    localparam logic [2:0] ADDR_FREC_MOD    = 3'd0;
    localparam logic [2:0] ADDR_SWEEP_START = 3'd1;
    localparam logic [2:0] ADDR_IM_AM       = 3'd2;
    localparam logic [2:0] ADDR_IM_FM       = 3'd3;
    localparam logic [2:0] ADDR_CTRL        = 3'd4;
    localparam logic [2:0] ADDR_SWEEP_STOP  = 3'd5;
    localparam logic [2:0] ADDR_SWEEP_STEP  = 3'd6;
    localparam logic [2:0] ADDR_DWELL       = 3'd7;

    // Control word layout: {sweep_en, c_comp_dac, c_source[1:0], c_fm_am}
    localparam int CTRL_W            = 5;
    localparam int CTRL_FM_AM_BIT    = 0;
    localparam int CTRL_SOURCE_LSB   = 1;
    localparam int CTRL_SOURCE_MSB   = 2;
    localparam int CTRL_COMP_DAC_BIT = 3;
    localparam int CTRL_SWEEP_EN_BIT = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // A dwell of zero behaves as a dwell of one (step on every val_in).
    function automatic logic [15:0] dwell_eff(input logic [15:0] dwell);
        return (dwell == 16'd0) ? 16'd1 : dwell;
    endfunction

endpackage

// File: rtl/mod_cfg_sequencer_carrier_sweep.sv
// Autonomous carrier sweep: counts val_in pulses and every dwell-th pulse
// advances frec_por by step, wrapping back to start on carry or past stop.
module carrier_sweep
    import mod_cfg_pkg::*;
#(
    parameter int M = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         load,
    input  logic [M-1:0] start,
    input  logic [M-1:0] stop,
    input  logic [M-1:0] step,
    input  logic [15:0]  dwell,
    input  logic         val_in,
    output logic [M-1:0] frec_por
);

    logic [M-1:0] frec_por_q;
    logic [15:0]  dwell_cnt_q;

    logic [M:0]   sum;
    logic         wrap;
    logic [M-1:0] stepped;
    logic         last_pulse;

    // Next carrier value and end-of-dwell detection
    always_comb begin
        sum        = {1'b0, frec_por_q} + {1'b0, step};
        wrap       = sum[M] | (sum[M-1:0] > stop);
        stepped    = wrap ? start : sum[M-1:0];
        last_pulse = (dwell_cnt_q + 16'd1) >= dwell_eff(dwell);
    end

    // Load on commit takes priority over a coincident step; frozen when disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            frec_por_q  <= '0;
            dwell_cnt_q <= '0;
        end else if (load) begin
            frec_por_q  <= start;
            dwell_cnt_q <= '0;
        end else if (enable && val_in) begin
            if (last_pulse) begin
                frec_por_q  <= stepped;
                dwell_cnt_q <= '0;
            end else begin
                dwell_cnt_q <= dwell_cnt_q + 16'd1;
            end
        end
    end

    assign frec_por = frec_por_q;

endmodule

// File: rtl/mod_cfg_sequencer.sv
// Configuration sequencer for the FM/AM modulator chain. Host writes land in a
// shadow bank; a commit is applied atomically on the next val_in while in RUN.
// Structural changes (mode, source, DAC compensation) flush the datapath and
// keep the output muted until the chain has produced SETTLE_SMP fresh samples.
module mod_cfg_sequencer
    import mod_cfg_pkg::*;
#(
    parameter int M          = 24,
    parameter int FLUSH_CYC  = 4,
    parameter int SETTLE_SMP = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         val_in,
    input  logic         dp_val,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [23:0]  wr_data,
    input  logic         commit,
    output logic [M-1:0] frec_mod,
    output logic [M-1:0] frec_por,
    output logic [15:0]  im_am,
    output logic [15:0]  im_fm,
    output logic         c_fm_am,
    output logic [1:0]   c_source,
    output logic         c_comp_dac,
    output logic         dp_rst,
    output logic         mute,
    output logic         busy
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int SW = (SETTLE_SMP > 1) ? $clog2(SETTLE_SMP) : 1;
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SMP - 1);

    // Shadow bank
    logic [M-1:0]      sh_frec_mod_q;
    logic [M-1:0]      sh_start_q;
    logic [M-1:0]      sh_stop_q;
    logic [M-1:0]      sh_step_q;
    logic [15:0]       sh_im_am_q;
    logic [15:0]       sh_im_fm_q;
    logic [15:0]       sh_dwell_q;
    logic [CTRL_W-1:0] sh_ctrl_q;

    // Active bank
    logic [M-1:0]      frec_mod_q;
    logic [M-1:0]      start_q;
    logic [M-1:0]      stop_q;
    logic [M-1:0]      step_q;
    logic [15:0]       im_am_q;
    logic [15:0]       im_fm_q;
    logic [15:0]       dwell_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Sequencing state
    state_e        state_q;
    logic [FW-1:0] flush_cnt_q;
    logic [SW-1:0] settle_cnt_q;
    logic          pend_q;
    logic          pend_d;
    logic          dp_rst_q;
    logic          mute_q;
    logic          busy_q;

    logic          copy;
    logic          ctrl_changed;
    logic          sweep_enable;
    logic [M-1:0]  sweep_start;

    // Commit bookkeeping. A commit in the same cycle as a copy re-arms pend so a
    // write issued with it is never lost.
    always_comb begin
        copy         = (state_q == ST_RUN) && pend_q && val_in;
        ctrl_changed = sh_ctrl_q[CTRL_COMP_DAC_BIT:CTRL_FM_AM_BIT]
                       != ctrl_q[CTRL_COMP_DAC_BIT:CTRL_FM_AM_BIT];
        pend_d       = commit | (pend_q & ~copy);
        sweep_enable = (state_q == ST_RUN) && ctrl_q[CTRL_SWEEP_EN_BIT];
        sweep_start  = copy ? sh_start_q : start_q;
    end

    // Host writes update the shadow bank only
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_frec_mod_q <= '0;
            sh_start_q    <= '0;
            sh_stop_q     <= '0;
            sh_step_q     <= '0;
            sh_im_am_q    <= '0;
            sh_im_fm_q    <= '0;
            sh_dwell_q    <= '0;
            sh_ctrl_q     <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_FREC_MOD:    sh_frec_mod_q <= M'(wr_data);
                ADDR_SWEEP_START: sh_start_q    <= M'(wr_data);
                ADDR_IM_AM:       sh_im_am_q    <= wr_data[15:0];
                ADDR_IM_FM:       sh_im_fm_q    <= wr_data[15:0];
                ADDR_CTRL:        sh_ctrl_q     <= wr_data[CTRL_W-1:0];
                ADDR_SWEEP_STOP:  sh_stop_q     <= M'(wr_data);
                ADDR_SWEEP_STEP:  sh_step_q     <= M'(wr_data);
                ADDR_DWELL:       sh_dwell_q    <= wr_data[15:0];
                default:          ;
            endcase
        end
    end

    // Atomic shadow-to-active copy on a sample boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            frec_mod_q <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            im_am_q    <= '0;
            im_fm_q    <= '0;
            dwell_q    <= '0;
            ctrl_q     <= '0;
        end else if (copy) begin
            frec_mod_q <= sh_frec_mod_q;
            start_q    <= sh_start_q;
            stop_q     <= sh_stop_q;
            step_q     <= sh_step_q;
            im_am_q    <= sh_im_am_q;
            im_fm_q    <= sh_im_fm_q;
            dwell_q    <= sh_dwell_q;
            ctrl_q     <= sh_ctrl_q;
        end
    end

    // Pending-commit flag; extra commits merge into the one already pending
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // RUN/FLUSH/SETTLE sequencer with registered dp_rst, mute and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            flush_cnt_q  <= '0;
            settle_cnt_q <= '0;
            dp_rst_q     <= 1'b0;
            mute_q       <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (copy && ctrl_changed) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                        dp_rst_q    <= 1'b1;
                        mute_q      <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        busy_q <= pend_d;
                    end
                end
                ST_FLUSH: begin
                    busy_q <= 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                        dp_rst_q     <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (dp_val) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= ST_RUN;
                            mute_q  <= 1'b0;
                            busy_q  <= pend_d;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= '0;
                    dp_rst_q     <= 1'b0;
                    mute_q       <= 1'b1;
                    busy_q       <= 1'b1;
                end
            endcase
        end
    end

    carrier_sweep #(
        .M(M)
    ) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .enable   (sweep_enable),
        .load     (copy),
        .start    (sweep_start),
        .stop     (stop_q),
        .step     (step_q),
        .dwell    (dwell_q),
        .val_in   (val_in),
        .frec_por (frec_por)
    );

    assign frec_mod   = frec_mod_q;
    assign im_am      = im_am_q;
    assign im_fm      = im_fm_q;
    assign c_fm_am    = ctrl_q[CTRL_FM_AM_BIT];
    assign c_source   = ctrl_q[CTRL_SOURCE_MSB:CTRL_SOURCE_LSB];
    assign c_comp_dac = ctrl_q[CTRL_COMP_DAC_BIT];
    assign dp_rst     = dp_rst_q;
    assign mute       = mute_q;
    assign busy       = busy_q;

endmodule

// File: doc/mod_cfg_sequencer.md
# mod_cfg_sequencer

Configuration and sequencing controller for the FM/AM modulator chain (DDS source, CIC compensator, CIC interpolator, modulation datapath). It holds a host-written shadow register bank and commits it atomically to the chain's control inputs on a sample boundary. When a structural setting changes, it flushes and mutes the pipeline so transients never reach the DAC. It can also sweep the carrier frequency autonomously.

## Interface
- `M`, 24: phase-increment width for `frec_mod` and `frec_por`.
- `FLUSH_CYC`, 4: clock cycles that `dp_rst` is held high during a flush.
- `SETTLE_SMP`, 64: number of `dp_val` pulses that `mute` stays high after a flush or reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `val_in` in 1: input sample strobe, the commit boundary.
- `dp_val` in 1: chain output valid, counted while settling.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 3: register address.
- `wr_data` in 24: write data, LSB-aligned.
- `commit` in 1: single-cycle request to apply the shadow bank.
- `frec_mod` out M: active modulating-tone increment.
- `frec_por` out M: active carrier increment (swept when enabled).
- `im_am` out 16: active AM index.
- `im_fm` out 16: active FM index.
- `c_fm_am` out 1: active mode select.
- `c_source` out 2: active source select.
- `c_comp_dac` out 1: active DAC compensation select.
- `dp_rst` out 1: datapath reset, ORed externally with `rst`.
- `mute` out 1: output gate; the downstream stage forces zero samples while it is high.
- `busy` out 1: high when a commit is pending or the state is not RUN.

## Operation
- Register map (unused high bits are ignored):
  - 0: `frec_mod`.
  - 1: `sweep_start`. This is also the `frec_por` value loaded at commit.
  - 2: `im_am` [15:0].
  - 3: `im_fm` [15:0].
  - 4: control, with `{sweep_en[4], c_comp_dac[3], c_source[2:1], c_fm_am[0]}`.
  - 5: `sweep_stop`.
  - 6: `sweep_step`.
  - 7: `dwell` [15:0]. A value of 0 is treated as 1.
- Writes go to the shadow bank only and never disturb the active outputs.
- `commit` sets the `pend` flag. Commits that arrive while `pend` is already set merge into the one pending commit.
- States:
  - RUN: if `pend` is set and `val_in` is high, copy shadow to active and clear `pend`. If any of {`c_fm_am`, `c_source`, `c_comp_dac`} changed, go to FLUSH; otherwise stay in RUN with no mute.
  - FLUSH: `dp_rst` = 1 and `mute` = 1 for `FLUSH_CYC` cycles, then go to SETTLE.
  - SETTLE: `mute` = 1 while `dp_val` pulses are counted. After `SETTLE_SMP` pulses, go to RUN.
- A commit arriving during FLUSH or SETTLE stays pending and is serviced in RUN. It is never dropped and never restarts the current flush.
- Sweep (RUN only, `sweep_en` = 1):
  - Count `val_in` pulses. On the `dwell`-th pulse, set `frec_por` ← `frec_por` + `sweep_step`, then reset the count.
  - If the M-bit sum carries, or exceeds `sweep_stop` (unsigned), load `sweep_start` instead.
  - The dwell count resets on every commit and is frozen outside RUN.
  - If `sweep_stop` < `sweep_start`, every step reloads `sweep_start`.

## Timing
- Reset values:
  - All active registers 0, including `frec_por` = 0.
  - All shadow registers 0.
  - `dp_rst` = 0, `mute` = 1, `busy` = 1.
  - `pend` = 0, state SETTLE with its count at 0.
- A write at cycle t is visible in the shadow bank at t+1. A write and a `commit` in the same cycle: the write is included in that commit.
- The copy happens in the cycle where `val_in` = 1 and `pend` = 1. Active outputs change at the next edge.
- When a flush is required, `dp_rst` and `mute` rise on that same edge.
- If `commit` and a sweep step coincide in one cycle, the commit wins and `frec_por` = `sweep_start`.
- `rst` asserted mid-operation aborts FLUSH, SETTLE or a pending commit. The next cycle shows the reset values.
- `dp_val` is ignored outside SETTLE. `val_in` is ignored outside RUN, except that it still counts toward the dwell in RUN.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `mod_cfg_pkg`:
  - Register address constants 0–7.
  - The control-field bit positions.
  - The state encoding {RUN, FLUSH, SETTLE}.
- Sub-module `carrier_sweep`: the dwell counter and the step/wrap adder.
  - Inputs: `clk`, `rst`, `enable`, `load`, `start`, `stop`, `step`, `dwell`, `val_in`.
  - Output: `frec_por`.
- The top level contains the shadow bank, the `pend` flag, the FSM and the flush/settle counters.

## Test plan
- Reset, then 64 `dp_val` pulses: `mute` = 1 through the 64th pulse and 0 the cycle after; `busy` = 0; all outputs 0.
- Write addr 2 = 0x1234, then `commit`, then `val_in` 5 cycles later: `im_am` = 0x1234 one cycle after that `val_in`; `dp_rst` never asserts; `mute` stays 0.
- Write addr 4 with `c_source` = 2, then commit: `dp_rst` high for exactly 4 cycles, `mute` high until 64 `dp_val` pulses; `c_source` = 2 from the commit edge.
- Second `commit` during SETTLE with `im_fm` changed: `im_fm` holds its old value until RUN, then updates on the first `val_in` in RUN.
- Sweep with start = 100, step = 50, stop = 220, dwell = 2: `frec_por` goes 100, 150, 200, 100, changing every 2nd `val_in`.
- `rst` asserted in the 2nd FLUSH cycle: next cycle `dp_rst` = 0, `mute` = 1, the pending commit is cleared and the outputs are 0.
